arrow_input: RTL and testbench

- Conditions the four raw arrow push-buttons and turns them into the direction request the snake game core samples every move tick.
- Per button: synchronise, debounce, edge-detect, polarity-normalise.
- Arbitrates simultaneous presses and rejects 180° reversals against the core's committed direction.
- Keeps a free-running 26-bit seed register, mixed with timing entropy on every press, for apple placement.

---
 rtl/arrow_input.sv | 191 +++++++++++++++++++
 tb/tb_arrow_input.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_input.sv
// ---------------------------------------------------------------------------
// arrow_input
//   Conditions the four raw arrow push-buttons into the direction request
//   that the snake game core samples on every move tick, and maintains the
//   pseudo-random seed used for apple placement.
//
//   Per button: 2-flop synchroniser -> polarity normalisation -> debounce ->
//   rising-edge (press) detection. Simultaneous presses are arbitrated
//   up > down > left > right. A press that would reverse the snake onto
//   itself (opposite of dire) is discarded and reported on reject_pulse.
//
// Ports
//   clk           system clock (10 MHz)
//   reset         asynchronous, active-low reset
//   arrow_up      raw up button pin (asynchronous)
//   arrow_down    raw down button pin (asynchronous)
//   arrow_left    raw left button pin (asynchronous)
//   arrow_right   raw right button pin (asynchronous)
//   dire[1:0]     direction last committed by the core (0 up,1 down,2 left,3 right)
//   arrow[1:0]    requested direction, same encoding as dire
//   accept_pulse  one-cycle strobe when arrow is updated
//   reject_pulse  one-cycle strobe when a press is discarded as a reversal
//   pressed[3:0]  debounced pressed levels {up,down,left,right}, active-high
//   seed[25:0]    pseudo-random seed, never zero
// ---------------------------------------------------------------------------
module arrow_input #(
    parameter int unsigned  DEBOUNCE_CYCLES  = 100000,
    parameter logic [3:0]   ACTIVE_HIGH_MASK = 4'b0011,
    parameter logic [25:0]  SEED_INIT        = 26'h2B3C4D5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arrow_up,
    input  logic        arrow_down,
    input  logic        arrow_left,
    input  logic        arrow_right,
    input  logic [1:0]  dire,
    output logic [1:0]  arrow,
    output logic        accept_pulse,
    output logic        reject_pulse,
    output logic [3:0]  pressed,
    output logic [25:0] seed
);

    localparam int unsigned     CNT_W      = 20;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level that means "not pressed" for each button.
    localparam logic [3:0]      IDLE_LEVEL = ~ACTIVE_HIGH_MASK;
    // x^6 + x^2 + x + 1 reduction term of x^26 + x^6 + x^2 + x + 1.
    localparam logic [25:0]     LFSR_TAPS  = 26'h0000047;

    logic [3:0] raw_pins;
    logic [3:0] level;

    assign raw_pins = {arrow_up, arrow_down, arrow_left, arrow_right};

    // -----------------------------------------------------------------------
    // Per-button conditioning
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_button
            logic             sync1_q;
            logic             sync2_q;
            logic             level_q;
            logic             level_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             sample;

            // After this XOR a 1 always means "pressed", whatever the pin polarity.
            assign sample = sync2_q ^ IDLE_LEVEL[gi];

            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                if (sample == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    // Sample has disagreed for DEBOUNCE_CYCLES consecutive cycles.
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q <= IDLE_LEVEL[gi];
                    sync2_q <= IDLE_LEVEL[gi];
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_pins[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign level[gi] = level_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Press detection, arbitration and reversal filter
    // -----------------------------------------------------------------------
    logic [3:0]  level_prev_q;
    logic [3:0]  press_evt;
    logic        has_event;
    logic [1:0]  cand;

    logic [1:0]  arrow_q,  arrow_d;
    logic        accept_q, accept_d;
    logic        reject_q, reject_d;
    logic [25:0] seed_q,   seed_d;
    logic [25:0] cyc_q,    cyc_d;
    logic [25:0] lfsr_next;
    logic [25:0] mixed;

    // Only 0->1 transitions count; releases are ignored.
    assign press_evt = level & ~level_prev_q;
    assign has_event = |press_evt;

    // Fixed priority up > down > left > right; losers are simply dropped.
    always_comb begin
        cand = 2'd3;
        if (press_evt[3]) begin
            cand = 2'd0;
        end else if (press_evt[2]) begin
            cand = 2'd1;
        end else if (press_evt[1]) begin
            cand = 2'd2;
        end else begin
            cand = 2'd3;
        end
    end

    // Multiply-by-x modulo the feedback polynomial (Galois form). Never maps a
    // non-zero state to zero because the polynomial has a constant term.
    assign lfsr_next = {seed_q[24:0], 1'b0} ^ ({26{seed_q[25]}} & LFSR_TAPS);
    assign mixed     = lfsr_next ^ cyc_q;

    always_comb begin
        arrow_d  = arrow_q;
        accept_d = 1'b0;
        reject_d = 1'b0;
        if (has_event) begin
            // Opposite pairs differ only in bit 0 of the encoding.
            if (cand == (dire ^ 2'b01)) begin
                reject_d = 1'b1;
            end else begin
                arrow_d  = cand;
                accept_d = 1'b1;
            end
        end
    end

    always_comb begin
        cyc_d  = cyc_q + 1'b1;
        seed_d = lfsr_next;
        if (has_event) begin
            seed_d = (mixed == '0) ? SEED_INIT : mixed;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev_q <= '0;
            arrow_q      <= 2'd0;
            accept_q     <= 1'b0;
            reject_q     <= 1'b0;
            seed_q       <= SEED_INIT;
            cyc_q        <= '0;
        end else begin
            level_prev_q <= level;
            arrow_q      <= arrow_d;
            accept_q     <= accept_d;
            reject_q     <= reject_d;
            seed_q       <= seed_d;
            cyc_q        <= cyc_d;
        end
    end

    assign arrow        = arrow_q;
    assign accept_pulse = accept_q;
    assign reject_pulse = reject_q;
    assign pressed      = level;
    assign seed         = seed_q;

endmodule

// File: tb/tb_arrow_input.sv
// ---------------------------------------------------------------------------
// tb_arrow_input
//   Directed bench for arrow_input with DEBOUNCE_CYCLES=4 and the default
//   mask. Inputs are driven and outputs sampled on the falling clock edge.
//   A reference seed/counter model steps on every rising edge; press events
//   are scheduled into it from the stimulus timeline (pin edge + 7 edges).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arrow_input;

    localparam logic [25:0] SEED_INIT_TB = 26'h2B3C4D5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arrow_up = 1'b1;
    logic        arrow_down = 1'b1;
    logic        arrow_left = 1'b0;
    logic        arrow_right = 1'b0;
    logic [1:0]  dire = 2'd0;
    logic [1:0]  arrow;
    logic        accept_pulse;
    logic        reject_pulse;
    logic [3:0]  pressed;
    logic [25:0] seed;

    int errors = 0;
    int checks = 0;

    arrow_input #(
        .DEBOUNCE_CYCLES  (4),
        .ACTIVE_HIGH_MASK (4'b0011),
        .SEED_INIT        (26'h2B3C4D5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arrow_up     (arrow_up),
        .arrow_down   (arrow_down),
        .arrow_left   (arrow_left),
        .arrow_right  (arrow_right),
        .dire         (dire),
        .arrow        (arrow),
        .accept_pulse (accept_pulse),
        .reject_pulse (reject_pulse),
        .pressed      (pressed),
        .seed         (seed)
    );

    always #50 clk = ~clk;

    // ---------------- reference seed model ----------------
    logic [25:0] m_seed = SEED_INIT_TB;
    logic [25:0] m_cnt  = '0;
    logic [25:0] m_nxt;
    int          edge_n = 0;
    int          upd_q[$];

    function automatic logic [25:0] lfsr_step(input logic [25:0] s);
        logic [25:0] r;
        r = {s[24:0], 1'b0};
        if (s[25]) r = r ^ 26'h0000047;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_seed = SEED_INIT_TB;
            m_cnt  = '0;
            edge_n = 0;
        end else begin
            m_nxt = lfsr_step(m_seed);
            if (upd_q.size() != 0 && upd_q[0] == edge_n + 1) begin
                void'(upd_q.pop_front());
                m_nxt = m_nxt ^ m_cnt;
                if (m_nxt == '0) m_nxt = SEED_INIT_TB;
            end
            m_seed = m_nxt;
            m_cnt  = m_cnt + 1'b1;
            edge_n = edge_n + 1;
        end
    end

    // ---------------- helpers (no comparisons) ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_count(input int n, output int acc, output int rej);
        acc = 0;
        rej = 0;
        repeat (n) begin
            @(negedge clk);
            acc += int'(accept_pulse);
            rej += int'(reject_pulse);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int acc, rej;
        step(3);
        checks++; if (arrow !== 2'd0) begin errors++; $display("FAIL reset_arrow: got %0d expected 0", arrow); end
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL reset_pressed: got %b expected 0000", pressed); end
        checks++; if (seed !== SEED_INIT_TB) begin errors++; $display("FAIL reset_seed: got %h expected %h", seed, SEED_INIT_TB); end
        checks++; if ({accept_pulse, reject_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {accept_pulse, reject_pulse}); end
        arrow_right = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        checks++; if ({accept_pulse, reject_pulse} !== 2'b00) begin errors++; $display("FAIL release_pulse1: got %b expected 00", {accept_pulse, reject_pulse}); end
        step(1);
        checks++; if ({accept_pulse, reject_pulse} !== 2'b00) begin errors++; $display("FAIL release_pulse2: got %b expected 00", {accept_pulse, reject_pulse}); end
        // Drop the pin before it can debounce (only 2 disagreeing samples).
        arrow_right = 1'b0;
        run_count(12, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL release_window: got %0d pulses expected 0", acc + rej); end
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL release_pressed: got %b expected 0000", pressed); end
        $display("test_reset done: arrow=%0d pressed=%b seed=%h", arrow, pressed, seed);
    endtask

    task automatic test_accept_right;
        int acc, rej;
        dire = 2'd0;
        arrow_right = 1'b1;
        upd_q.push_back(edge_n + 7);
        step(5);
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL right_early: got %b expected 0000", pressed); end
        step(1);
        checks++; if (pressed !== 4'b0001) begin errors++; $display("FAIL right_pressed: got %b expected 0001", pressed); end
        checks++; if (accept_pulse !== 1'b0) begin errors++; $display("FAIL right_acc_early: got %b expected 0", accept_pulse); end
        step(1);
        checks++; if ({accept_pulse, reject_pulse} !== 2'b10) begin errors++; $display("FAIL right_accept: got %b expected 10", {accept_pulse, reject_pulse}); end
        checks++; if (arrow !== 2'd3) begin errors++; $display("FAIL right_arrow: got %0d expected 3", arrow); end
        run_count(8, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL right_single: got %0d extra pulses expected 0", acc + rej); end
        arrow_right = 1'b0;
        run_count(10, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL right_release: got %0d pulses expected 0", acc + rej); end
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL right_released: got %b expected 0000", pressed); end
        $display("test_accept_right done: arrow=%0d", arrow);
    endtask

    task automatic test_glitch_reject;
        int acc, rej;
        dire = 2'd3;
        arrow_left = 1'b1;
        step(3);
        arrow_left = 1'b0;
        run_count(12, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", acc + rej); end
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL glitch_pressed: got %b expected 0000", pressed); end
        arrow_left = 1'b1;
        upd_q.push_back(edge_n + 7);
        step(7);
        checks++; if ({accept_pulse, reject_pulse} !== 2'b01) begin errors++; $display("FAIL left_reject: got %b expected 01", {accept_pulse, reject_pulse}); end
        checks++; if (arrow !== 2'd3) begin errors++; $display("FAIL left_arrow_hold: got %0d expected 3", arrow); end
        run_count(8, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL left_single: got %0d extra pulses expected 0", acc + rej); end
        arrow_left = 1'b0;
        step(10);
        $display("test_glitch_reject done: arrow=%0d", arrow);
    endtask

    task automatic test_simultaneous;
        int acc, rej;
        dire = 2'd2;
        arrow_up = 1'b0;
        arrow_down = 1'b0;
        upd_q.push_back(edge_n + 7);
        step(6);
        checks++; if (pressed !== 4'b1100) begin errors++; $display("FAIL simul_pressed: got %b expected 1100", pressed); end
        step(1);
        checks++; if ({accept_pulse, reject_pulse} !== 2'b10) begin errors++; $display("FAIL simul_accept: got %b expected 10", {accept_pulse, reject_pulse}); end
        checks++; if (arrow !== 2'd0) begin errors++; $display("FAIL simul_arrow: got %0d expected 0", arrow); end
        run_count(10, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL simul_single: got %0d extra pulses expected 0", acc + rej); end
        $display("test_simultaneous done: arrow=%0d", arrow);
    endtask

    task automatic test_back_to_back;
        int acc, rej, acc_tot, rej_tot;
        arrow_up = 1'b1;
        arrow_down = 1'b1;
        run_count(12, acc, rej);
        checks++; if (acc + rej !== 0) begin errors++; $display("FAIL b2b_release: got %0d pulses expected 0", acc + rej); end
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL b2b_idle: got %b expected 0000", pressed); end
        dire = 2'd2;
        acc_tot = 0; rej_tot = 0;
        arrow_down = 1'b0;
        upd_q.push_back(edge_n + 7);
        run_count(7, acc, rej); acc_tot += acc; rej_tot += rej;
        checks++; if (arrow !== 2'd1) begin errors++; $display("FAIL b2b_arrow1: got %0d expected 1", arrow); end
        run_count(5, acc, rej); acc_tot += acc; rej_tot += rej;
        arrow_down = 1'b1;
        run_count(12, acc, rej); acc_tot += acc; rej_tot += rej;
        checks++; if (pressed !== 4'b0000) begin errors++; $display("FAIL b2b_released: got %b expected 0000", pressed); end
        arrow_down = 1'b0;
        upd_q.push_back(edge_n + 7);
        run_count(12, acc, rej); acc_tot += acc; rej_tot += rej;
        checks++; if (acc_tot !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_tot); end
        checks++; if (rej_tot !== 0) begin errors++; $display("FAIL b2b_rejects: got %0d expected 0", rej_tot); end
        checks++; if (pressed !== 4'b0100) begin errors++; $display("FAIL b2b_held: got %b expected 0100", pressed); end
        arrow_down = 1'b1;
        step(12);
        $display("test_back_to_back done: accepts=%0d arrow=%0d", acc_tot, arrow);
    endtask

    task automatic test_seed;
        logic [25:0] prev, c_val, exp_seed;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            checks++;
            if (seed !== m_seed) begin
                errors++;
                if (bad < 5) $display("FAIL seed_run[%0d]: got %h expected %h", i, seed, m_seed);
                bad++;
            end
            checks++;
            if (seed === 26'h0) begin errors++; $display("FAIL seed_zero[%0d]: got 0 expected non-zero", i); end
        end
        dire = 2'd2;
        arrow_left = 1'b1;
        upd_q.push_back(edge_n + 7);
        step(6);
        prev  = m_seed;
        c_val = m_cnt;
        exp_seed = lfsr_step(prev) ^ c_val;
        if (exp_seed == 26'h0) exp_seed = SEED_INIT_TB;
        step(1);
        checks++; if (seed !== exp_seed) begin errors++; $display("FAIL seed_press: got %h expected %h (C=%h)", seed, exp_seed, c_val); end
        checks++; if ({accept_pulse, reject_pulse} !== 2'b10) begin errors++; $display("FAIL seed_press_accept: got %b expected 10", {accept_pulse, reject_pulse}); end
        checks++; if (arrow !== 2'd2) begin errors++; $display("FAIL seed_press_arrow: got %0d expected 2", arrow); end
        arrow_left = 1'b0;
        step(12);
        checks++; if (seed !== m_seed) begin errors++; $display("FAIL seed_final: got %h expected %h", seed, m_seed); end
        $display("test_seed done: C=%h seed=%h", c_val, seed);
    endtask

    initial begin
        test_reset();
        test_accept_right();
        test_glitch_reject();
        test_simultaneous();
        test_back_to_back();
        test_seed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
